// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: the BPU update bundle, the grouped
// resolve request, the BTB classification and the resolve FSM state encoding.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    BTB_JUMP   = 2'd0,
    BTB_BRANCH = 2'd1,
    BTB_RETURN = 2'd2
  } btb_type_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] actual_target;
    logic        actual_taken;
    logic        is_branch_inst;
    logic        is_call_inst;
    logic        is_ret_inst;
    logic        same_link_regs;
    logic        is_miss_predict;
    btb_type_t   btb_type;
  } bpu_update_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_branch;
    logic        is_call;
    logic        is_ret;
    logic        same_link_regs;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        pred_valid;
    logic [31:0] pred_target;
  } res_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } brc_state_t;

  // A call+ret encoding (coroutine swap) is classified as a plain jump.
  function automatic btb_type_t classify_btb(input logic is_branch,
                                             input logic is_call,
                                             input logic is_ret);
    if (is_branch)
      return BTB_BRANCH;
    if (is_ret && !is_call)
      return BTB_RETURN;
    return BTB_JUMP;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the resolve and mispredict performance counters.
module brc_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares resolved control flow against the frontend prediction, issues one
// registered BPU update per live resolve and drives the mispredict redirect.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int EPOCH_WIDTH = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_valid,
  input  logic [31:0]            res_pc,
  input  logic                   res_is_branch,
  input  logic                   res_is_call,
  input  logic                   res_is_ret,
  input  logic                   res_same_link_regs,
  input  logic                   res_actual_taken,
  input  logic [31:0]            res_actual_target,
  input  logic                   res_pred_valid,
  input  logic [31:0]            res_pred_target,
  input  logic [EPOCH_WIDTH-1:0] res_epoch,
  input  logic                   trap_flush,
  output bpu_update_req_t        update_req,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  input  logic                   redirect_ready,
  output logic                   flush,
  output logic [EPOCH_WIDTH-1:0] cur_epoch,
  output logic [CNT_WIDTH-1:0]   resolved_cnt,
  output logic [CNT_WIDTH-1:0]   mispredict_cnt
);

  typedef logic [EPOCH_WIDTH-1:0] epoch_t;

  res_req_t        res;
  brc_state_t      state;
  brc_state_t      state_next;
  bpu_update_req_t update_next;
  logic [31:0]     pred_npc;
  logic [31:0]     act_npc;
  logic            miss;
  logic            live;
  logic            miss_live;

  assign res = '{valid:          res_valid,
                 pc:             res_pc,
                 is_branch:      res_is_branch,
                 is_call:        res_is_call,
                 is_ret:         res_is_ret,
                 same_link_regs: res_same_link_regs,
                 actual_taken:   res_actual_taken,
                 actual_target:  res_actual_target,
                 pred_valid:     res_pred_valid,
                 pred_target:    res_pred_target};

  // Anything resolving while a redirect is outstanding is wrong-path, whatever its tag.
  always_comb begin
    pred_npc  = res.pred_valid   ? res.pred_target   : res.pc + 32'd4;
    act_npc   = res.actual_taken ? res.actual_target : res.pc + 32'd4;
    miss      = (pred_npc != act_npc);
    live      = res.valid && (res_epoch == cur_epoch) && !trap_flush && (state == ST_IDLE);
    miss_live = live && miss;
  end

  always_comb begin
    update_next                 = '0;
    update_next.valid           = 1'b1;
    update_next.pc              = res.pc;
    update_next.actual_target   = res.actual_target;
    update_next.actual_taken    = res.actual_taken;
    update_next.is_branch_inst  = res.is_branch;
    update_next.is_call_inst    = res.is_call;
    update_next.is_ret_inst     = res.is_ret;
    update_next.same_link_regs  = res.same_link_regs;
    update_next.is_miss_predict = miss;
    update_next.btb_type        = classify_btb(res.is_branch, res.is_call, res.is_ret);
  end

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (miss_live) state_next = ST_REDIRECT;
      ST_REDIRECT: if (trap_flush || redirect_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      update_req     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      cur_epoch      <= '0;
    end else begin
      state          <= state_next;
      update_req     <= live ? update_next : '0;
      redirect_valid <= (state_next == ST_REDIRECT);
      flush          <= miss_live;
      if (miss_live)
        redirect_pc <= act_npc;
      // A trap opens a new epoch too; its own flush is driven by the trap path.
      if (miss_live || trap_flush)
        cur_epoch <= cur_epoch + epoch_t'(1);
    end
  end

  brc_sat_counter #(.WIDTH(CNT_WIDTH)) u_resolved_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (live),
    .count (resolved_cnt)
  );

  brc_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_live),
    .count (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table for single resolves plus
// hand sequences for redirect hold, squash, trap, counter saturation and async reset.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int EW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            res_valid;
  logic [31:0]     res_pc;
  logic            res_is_branch;
  logic            res_is_call;
  logic            res_is_ret;
  logic            res_same_link_regs;
  logic            res_actual_taken;
  logic [31:0]     res_actual_target;
  logic            res_pred_valid;
  logic [31:0]     res_pred_target;
  logic [EW-1:0]   res_epoch;
  logic            trap_flush;
  bpu_update_req_t update_req;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            redirect_ready;
  logic            flush;
  logic [EW-1:0]   cur_epoch;
  logic [CW-1:0]   resolved_cnt;
  logic [CW-1:0]   mispredict_cnt;

  branch_resolve_unit #(.EPOCH_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .res_valid          (res_valid),
    .res_pc             (res_pc),
    .res_is_branch      (res_is_branch),
    .res_is_call        (res_is_call),
    .res_is_ret         (res_is_ret),
    .res_same_link_regs (res_same_link_regs),
    .res_actual_taken   (res_actual_taken),
    .res_actual_target  (res_actual_target),
    .res_pred_valid     (res_pred_valid),
    .res_pred_target    (res_pred_target),
    .res_epoch          (res_epoch),
    .trap_flush         (trap_flush),
    .update_req         (update_req),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .redirect_ready     (redirect_ready),
    .flush              (flush),
    .cur_epoch          (cur_epoch),
    .resolved_cnt       (resolved_cnt),
    .mispredict_cnt     (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        is_branch;
    logic        is_call;
    logic        is_ret;
    logic        same_link;
    logic        taken;
    logic [31:0] target;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic        exp_miss;
    logic [31:0] exp_npc;
    btb_type_t   exp_btb;
  } vec_t;

  vec_t vecs[7];

  int            errors = 0;
  int            checks = 0;
  logic [EW-1:0] exp_epoch;
  logic [CW-1:0] exp_rcnt;
  logic [CW-1:0] exp_mcnt;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [CW-1:0] sat_bump(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic br, input logic call,
                           input logic ret, input logic sl, input logic taken,
                           input logic [31:0] tgt, input logic pv, input logic [31:0] pt,
                           input logic [EW-1:0] ep);
    res_valid          = 1'b1;
    res_pc             = pc;
    res_is_branch      = br;
    res_is_call        = call;
    res_is_ret         = ret;
    res_same_link_regs = sl;
    res_actual_taken   = taken;
    res_actual_target  = tgt;
    res_pred_valid     = pv;
    res_pred_target    = pt;
    res_epoch          = ep;
  endtask

  task automatic clear_res();
    res_valid          = 1'b0;
    res_pc             = '0;
    res_is_branch      = 1'b0;
    res_is_call        = 1'b0;
    res_is_ret         = 1'b0;
    res_same_link_regs = 1'b0;
    res_actual_taken   = 1'b0;
    res_actual_target  = '0;
    res_pred_valid     = 1'b0;
    res_pred_target    = '0;
    res_epoch          = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_upd"},   64'(update_req), 64'd0);
    check({tag, "_rv"},    64'(redirect_valid), 64'd0);
    check({tag, "_rpc"},   64'(redirect_pc), 64'd0);
    check({tag, "_flush"}, 64'(flush), 64'd0);
    check({tag, "_epoch"}, 64'(cur_epoch), 64'd0);
    check({tag, "_rcnt"},  64'(resolved_cnt), 64'd0);
    check({tag, "_mcnt"},  64'(mispredict_cnt), 64'd0);
  endtask

  initial begin
    //            pc            br   call ret  sl   tkn  target        pv   pred_tgt      miss npc           btb
    vecs[0] = '{32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_1004, BTB_BRANCH};
    vecs[1] = '{32'h0000_3000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4008, 1'b1, 32'h0000_4000, 1'b1, 32'h0000_4008, BTB_RETURN};
    vecs[2] = '{32'h0000_3100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_5000, 1'b0, 32'h0000_5000, BTB_JUMP};
    vecs[3] = '{32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2400, 1'b1, 32'h0000_2400, 1'b1, 32'h0000_2004, BTB_BRANCH};
    vecs[4] = '{32'h0000_6000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_7000, 1'b1, 32'h0000_7000, 1'b0, 32'h0000_7000, BTB_JUMP};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, BTB_BRANCH};
    vecs[6] = '{32'h0000_8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_9000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_9000, BTB_JUMP};

    rst_n          = 1'b0;
    trap_flush     = 1'b0;
    redirect_ready = 1'b0;
    clear_res();
    exp_epoch = '0;
    exp_rcnt  = '0;
    exp_mcnt  = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Table: one live resolve each, acknowledging any redirect immediately.
    for (int i = 0; i < 7; i++) begin
      drive_res(vecs[i].pc, vecs[i].is_branch, vecs[i].is_call, vecs[i].is_ret,
                vecs[i].same_link, vecs[i].taken, vecs[i].target,
                vecs[i].pred_valid, vecs[i].pred_target, exp_epoch);
      step();
      clear_res();
      exp_rcnt = sat_bump(exp_rcnt);
      if (vecs[i].exp_miss) begin
        exp_mcnt  = sat_bump(exp_mcnt);
        exp_epoch = exp_epoch + EW'(1);
      end
      check($sformatf("v%0d_valid", i),  64'(update_req.valid), 64'd1);
      check($sformatf("v%0d_pc", i),     64'(update_req.pc), 64'(vecs[i].pc));
      check($sformatf("v%0d_tgt", i),    64'(update_req.actual_target), 64'(vecs[i].target));
      check($sformatf("v%0d_taken", i),  64'(update_req.actual_taken), 64'(vecs[i].taken));
      check($sformatf("v%0d_flags", i),
            64'({update_req.is_branch_inst, update_req.is_call_inst,
                 update_req.is_ret_inst, update_req.same_link_regs}),
            64'({vecs[i].is_branch, vecs[i].is_call, vecs[i].is_ret, vecs[i].same_link}));
      check($sformatf("v%0d_miss", i),   64'(update_req.is_miss_predict), 64'(vecs[i].exp_miss));
      check($sformatf("v%0d_btb", i),    64'(update_req.btb_type), 64'(vecs[i].exp_btb));
      check($sformatf("v%0d_flush", i),  64'(flush), 64'(vecs[i].exp_miss));
      check($sformatf("v%0d_rv", i),     64'(redirect_valid), 64'(vecs[i].exp_miss));
      check($sformatf("v%0d_epoch", i),  64'(cur_epoch), 64'(exp_epoch));
      check($sformatf("v%0d_rcnt", i),   64'(resolved_cnt), 64'(exp_rcnt));
      check($sformatf("v%0d_mcnt", i),   64'(mispredict_cnt), 64'(exp_mcnt));
      if (vecs[i].exp_miss) begin
        check($sformatf("v%0d_rpc", i), 64'(redirect_pc), 64'(vecs[i].exp_npc));
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check($sformatf("v%0d_rv_done", i), 64'(redirect_valid), 64'd0);
      end else begin
        step();
      end
      check($sformatf("v%0d_pulse", i), 64'(update_req.valid), 64'd0);
      check($sformatf("v%0d_flush_1c", i), 64'(flush), 64'd0);
    end

    // Mispredicted taken branch; redirect held while ready is low, wrong-path squashed.
    drive_res(32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0, exp_epoch);
    step();
    clear_res();
    exp_rcnt  = sat_bump(exp_rcnt);
    exp_mcnt  = sat_bump(exp_mcnt);
    exp_epoch = exp_epoch + EW'(1);
    check("hold_flush", 64'(flush), 64'd1);
    check("hold_rv",    64'(redirect_valid), 64'd1);
    check("hold_rpc",   64'(redirect_pc), 64'h2000);
    check("hold_epoch", 64'(cur_epoch), 64'(exp_epoch));
    check("hold_mcnt",  64'(mispredict_cnt), 64'(exp_mcnt));
    for (int c = 0; c < 3; c++) begin
      drive_res(32'h0000_1004 + 32'(4 * c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_7777,
                1'b0, 32'h0, exp_epoch - EW'(1));
      step();
      clear_res();
      check($sformatf("hold%0d_rv", c),    64'(redirect_valid), 64'd1);
      check($sformatf("hold%0d_rpc", c),   64'(redirect_pc), 64'h2000);
      check($sformatf("hold%0d_flush", c), 64'(flush), 64'd0);
      check($sformatf("hold%0d_upd", c),   64'(update_req.valid), 64'd0);
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    check("hold_rv_done", 64'(redirect_valid), 64'd0);

    drive_res(32'h0000_1004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0,
              exp_epoch - EW'(1));
    step();
    clear_res();
    check("squash_upd",   64'(update_req.valid), 64'd0);
    check("squash_rv",    64'(redirect_valid), 64'd0);
    check("squash_flush", 64'(flush), 64'd0);
    check("squash_epoch", 64'(cur_epoch), 64'(exp_epoch));
    check("squash_cnts",  64'({resolved_cnt, mispredict_cnt}), 64'({exp_rcnt, exp_mcnt}));

    // Trap while a redirect is pending: redirect dropped, resolve squashed, no flush.
    drive_res(32'h0000_A000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_B000, 1'b0, 32'h0, exp_epoch);
    step();
    exp_rcnt  = sat_bump(exp_rcnt);
    exp_mcnt  = sat_bump(exp_mcnt);
    exp_epoch = exp_epoch + EW'(1);
    check("trap_pre_rv", 64'(redirect_valid), 64'd1);
    drive_res(32'h0000_B000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_C000, 1'b0, 32'h0, exp_epoch);
    trap_flush = 1'b1;
    step();
    trap_flush = 1'b0;
    clear_res();
    exp_epoch = exp_epoch + EW'(1);
    check("trap_rv",    64'(redirect_valid), 64'd0);
    check("trap_epoch", 64'(cur_epoch), 64'(exp_epoch));
    check("trap_upd",   64'(update_req.valid), 64'd0);
    check("trap_flush", 64'(flush), 64'd0);
    check("trap_cnts",  64'({resolved_cnt, mispredict_cnt}), 64'({exp_rcnt, exp_mcnt}));
    step();
    check("trap_idle_rv", 64'(redirect_valid), 64'd0);

    // Back-to-back correct resolves drive the narrow counter into saturation.
    drive_res(32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, exp_epoch);
    for (int k = 0; k < 20; k++) begin
      step();
      exp_rcnt = sat_bump(exp_rcnt);
    end
    clear_res();
    check("sat_rcnt",  64'(resolved_cnt), 64'hF);
    check("sat_model", 64'(resolved_cnt), 64'(exp_rcnt));
    check("sat_mcnt",  64'(mispredict_cnt), 64'(exp_mcnt));

    // Async reset in the middle of a pending redirect.
    drive_res(32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0, 32'h0, exp_epoch);
    step();
    clear_res();
    check("rst_pre_rv", 64'(redirect_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #3;
    rst_n = 1'b1;
    step();
    check("post_rst_rv", 64'(redirect_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Backend-side producer of bpu_update_req_t and the frontend redirect. It takes resolved control-flow instructions from the EXU and compares the actual next PC against the frontend's prediction. It then emits one registered BPU update per resolved instruction and, on a mispredict, raises a held redirect plus a one-cycle flush. Younger wrong-path resolves are squashed using an epoch tag.

Parameters:
EPOCH_WIDTH, 2, width of epoch tag carried with each fetched/resolved instruction
CNT_WIDTH, 32, width of saturating perf counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
res_valid  in  1  EXU resolve strobe, one instruction per cycle
res_pc  in  32  resolving instruction PC
res_is_branch  in  1  conditional branch
res_is_call  in  1  call (link-reg write)
res_is_ret  in  1  return (link-reg read)
res_same_link_regs  in  1  rs1==rd for call+ret encodings
res_actual_taken  in  1  actual direction (1 for all jumps)
res_actual_target  in  32  actual taken target
res_pred_valid  in  1  frontend predicted taken
res_pred_target  in  32  frontend predicted target
res_epoch  in  EPOCH_WIDTH  epoch at fetch
trap_flush  in  1  higher-priority flush (exception/trap)
update_req  out  $bits(bpu_update_req_t)  to BPU
redirect_valid  out  1  redirect request to PC gen
redirect_pc  out  32  correct next PC
redirect_ready  in  1  PC gen accepts redirect
flush  out  1  one-cycle pipeline flush pulse
cur_epoch  out  EPOCH_WIDTH  epoch the frontend tags new fetches with
resolved_cnt  out  CNT_WIDTH  count of non-squashed resolves
mispredict_cnt  out  CNT_WIDTH  count of mispredicts

Behaviour:
- Reset (rst_n low, async): update_req all-zero (valid=0), redirect_valid=0, redirect_pc=0, flush=0, cur_epoch=0, both counters=0, FSM=IDLE.
- Live resolve: res_valid && res_epoch==cur_epoch && !trap_flush. A non-live resolve is squashed: no update, no count, no redirect.
- pred_npc = res_pred_valid ? res_pred_target : res_pc+4. act_npc = res_actual_taken ? res_actual_target : res_pc+4. Arithmetic is 32-bit wrap.
- miss = (pred_npc != act_npc).
- Latency: every output derived from a live resolve appears exactly 1 cycle later. All outputs are registered.
- update_req fields, driven the cycle after a live resolve:
  - valid=1, pc=res_pc, actual_target=res_actual_target, actual_taken=res_actual_taken.
  - is_branch_inst=res_is_branch, is_call_inst=res_is_call, is_ret_inst=res_is_ret, same_link_regs passthrough.
  - is_miss_predict=miss.
  - btb_type: BRANCH if res_is_branch; RETURN if res_is_ret && !res_is_call; otherwise JUMP.
  - update_req.valid is 0 in every other cycle. It is a pulse and has no backpressure.
- FSM IDLE:
  - Live resolve with miss: increment cur_epoch (wraps mod 2^EPOCH_WIDTH).
  - Next cycle: flush=1 (one cycle), redirect_valid=1, redirect_pc=act_npc. Go to REDIRECT.
- FSM REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_valid && redirect_ready, then go to IDLE.
  - redirect_ready in the first REDIRECT cycle completes the handshake that cycle.
  - Resolves arriving in REDIRECT carry the old epoch and are squashed.
  - A same-epoch resolve in REDIRECT is impossible (in-order resolve). If one occurs, it is squashed anyway.
- trap_flush, any state:
  - cur_epoch increments.
  - A resolve in the same cycle is squashed.
  - A pending redirect is dropped: redirect_valid=0 next cycle, FSM=IDLE.
  - The flush output is not pulsed; the trap path owns that flush.
  - An already-registered update_req still issues.
- Counters saturate at all-ones.
  - resolved_cnt increments per live resolve.
  - mispredict_cnt increments per live miss.
- Simultaneous miss and redirect_ready in REDIRECT cannot happen (the miss would be squashed).

Decomposition:
- bundle package: bpu_update_req_t, btb_type_t (already shared); add res_req_t grouping the res_* inputs, and epoch_t.
- bitutils package: sat_inc function.
- No sub-module needed beyond one inline sat counter. An optional brc_sat_counter may be instantiated twice.

Test Plan:
1. Conditional branch pc=0x1000, pred_valid=0, actual_taken=0, epoch=0 -> next cycle update_req.valid=1, is_miss_predict=0, btb_type=BRANCH; no flush/redirect; resolved_cnt=1.
2. Branch pc=0x1000, pred_valid=0, taken to 0x2000 -> next cycle flush=1 (1 cycle), redirect_valid=1, redirect_pc=0x2000, cur_epoch=1, mispredict_cnt=1. Hold redirect_ready=0 for 3 cycles -> redirect stable; ready=1 -> redirect_valid=0 next cycle.
3. Immediately after test 2, resolve with epoch=0 pc=0x1004 mispredicted -> squashed: no update_req, counters unchanged, cur_epoch stays 1.
4. Ret pc=0x3000, pred target 0x4000, actual 0x4008 -> btb_type=RETURN, is_miss_predict=1, redirect_pc=0x4008. Call with pred 0x5000 equal to actual -> btb_type=JUMP, is_call_inst=1, no redirect.
5. In REDIRECT assert trap_flush with a live resolve -> redirect_valid=0 next cycle, epoch +1, resolve squashed, flush not pulsed.
6. Preload counters near all-ones (CNT_WIDTH=4 build); 20 live resolves -> resolved_cnt stays 0xF. Async rst_n low mid-REDIRECT -> all outputs zero immediately.
